// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: classifies one retire event per clock, timestamps/numbers it, and buffers it FWFT.
// Optional build macro RETIRE_TRACE_STAMP_EN adds a per-entry 16-bit cycle stamp.
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        hlt,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic        out_load,
  output logic [15:0] out_inum,
  output logic [15:0] out_pc,
  output logic [3:0]  out_reg,
  output logic [15:0] out_value,
  output logic [15:0] out_addr,
  output logic [15:0] out_stamp,
  output logic        halted,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] K_NOP   = 2'b00;
  localparam logic [1:0] K_REG   = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [1:0] K_HALT  = 2'b11;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_halted, r_overflow;
  logic [7:0]    r_drop;
  logic [15:0]   r_inum;

  logic [1:0]  r_kind_mem  [DEPTH];
  logic        r_load_mem  [DEPTH];
  logic [15:0] r_inum_mem  [DEPTH];
  logic [15:0] r_pc_mem    [DEPTH];
  logic [3:0]  r_reg_mem   [DEPTH];
  logic [15:0] r_value_mem [DEPTH];
  logic [15:0] r_addr_mem  [DEPTH];

  logic [1:0]    w_kind;
  logic          w_load;
  logic [3:0]    w_reg;
  logic [15:0]   w_value, w_addr;
  logic          w_valid, w_full, w_cap, w_pop;
  logic          w_push_ok, w_halt_ovr, w_drop, w_wr_en;
  logic [AW-1:0] w_wr_idx;

  // Classification: reg_write beats hlt beats mem_write.
  always_comb begin
    w_kind  = K_NOP;
    w_load  = 1'b0;
    w_reg   = 4'd0;
    w_value = 16'd0;
    w_addr  = 16'd0;
    if (reg_write) begin
      w_kind  = K_REG;
      w_load  = mem_read;
      w_reg   = write_reg;
      w_value = write_data;
      w_addr  = mem_read ? mem_addr : 16'd0;
    end else if (hlt) begin
      w_kind  = K_HALT;
    end else if (mem_write) begin
      w_kind  = K_STORE;
      w_value = mem_data;
      w_addr  = mem_addr;
    end
  end

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_cap      = ~r_halted;
  assign w_pop      = w_valid & out_ready;
  assign w_push_ok  = w_cap & (~w_full | w_pop);
  assign w_drop     = w_cap & w_full & ~w_pop;
  // A HALT that finds the FIFO full replaces the newest entry rather than being lost.
  assign w_halt_ovr = w_drop & (w_kind == K_HALT);
  assign w_wr_en    = w_push_ok | w_halt_ovr;
  assign w_wr_idx   = w_push_ok ? r_wptr : (r_wptr - AW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_halted   <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= 8'd0;
      r_inum     <= 16'd0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_cap) begin
        r_inum <= r_inum + 16'd1;
        if (w_kind == K_HALT) r_halted <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_kind_mem[w_wr_idx]  <= w_kind;
      r_load_mem[w_wr_idx]  <= w_load;
      r_inum_mem[w_wr_idx]  <= r_inum;
      r_pc_mem[w_wr_idx]    <= pc;
      r_reg_mem[w_wr_idx]   <= w_reg;
      r_value_mem[w_wr_idx] <= w_value;
      r_addr_mem[w_wr_idx]  <= w_addr;
    end
  end

`ifdef RETIRE_TRACE_STAMP_EN
  logic [15:0] r_stamp;
  logic [15:0] r_stamp_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stamp <= 16'd0;
    else        r_stamp <= r_stamp + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_stamp_mem[w_wr_idx] <= r_stamp;
  end

  assign out_stamp = w_valid ? r_stamp_mem[r_rptr] : 16'd0;
`else
  assign out_stamp = 16'd0;
`endif

  always_comb begin
    out_kind  = 2'b00;
    out_load  = 1'b0;
    out_inum  = 16'd0;
    out_pc    = 16'd0;
    out_reg   = 4'd0;
    out_value = 16'd0;
    out_addr  = 16'd0;
    if (w_valid) begin
      out_kind  = r_kind_mem[r_rptr];
      out_load  = r_load_mem[r_rptr];
      out_inum  = r_inum_mem[r_rptr];
      out_pc    = r_pc_mem[r_rptr];
      out_reg   = r_reg_mem[r_rptr];
      out_value = r_value_mem[r_rptr];
      out_addr  = r_addr_mem[r_rptr];
    end
  end

  assign out_valid  = w_valid;
  assign halted     = r_halted;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: queue-based reference model fed per clock, negedge monitor compares.
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, hlt = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [15:0] write_data = '0, mem_addr = '0, mem_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [1:0]  out_kind;
  logic        out_load;
  logic [15:0] out_inum, out_pc, out_value, out_addr, out_stamp;
  logic [3:0]  out_reg;
  logic        halted, overflow;
  logic [7:0]  drop_count;

  retire_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .hlt(hlt),
    .write_reg(write_reg), .write_data(write_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_load(out_load), .out_inum(out_inum), .out_pc(out_pc),
    .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr), .out_stamp(out_stamp),
    .halted(halted), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic        load;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [15:0] stamp;
  } ev_t;

  ev_t         exp_q[$];
  bit          pop_pending;
  logic [15:0] m_inum, m_cyc;
  logic [7:0]  m_drop;
  logic        m_ovf, m_halted;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pop_pending = 0;
    m_inum = 0; m_cyc = 0; m_drop = 0; m_ovf = 0; m_halted = 0;
  endtask

  // Reference behaviour for one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    ev_t e;
    int  occ;
    if (!m_halted) begin
      e = '0;
      e.inum = m_inum;
      e.pc   = pc;
`ifdef RETIRE_TRACE_STAMP_EN
      e.stamp = m_cyc;
`endif
      if (reg_write) begin
        e.kind = 2'd1; e.load = mem_read; e.rg = write_reg; e.value = write_data;
        e.addr = mem_read ? mem_addr : 16'd0;
      end else if (hlt) begin
        e.kind = 2'd3;
      end else if (mem_write) begin
        e.kind = 2'd2; e.addr = mem_addr; e.value = mem_data;
      end
      occ = exp_q.size() + (pop_pending ? 1 : 0);
      if (occ < DEPTH || pop_pending) begin
        exp_q.push_back(e);
      end else begin
        if (e.kind == 2'd3) exp_q[exp_q.size()-1] = e;
        m_ovf = 1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
      m_inum = m_inum + 16'd1;
      if (e.kind == 2'd3) m_halted = 1;
    end
    m_cyc = m_cyc + 16'd1;
    pop_pending = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
      if (out_valid && exp_q.size() > 0) begin
        chk("head.kind", 32'(out_kind), 32'(exp_q[0].kind));
        chk("head.load", 32'(out_load), 32'(exp_q[0].load));
        chk("head.inum", 32'(out_inum), 32'(exp_q[0].inum));
        chk("head.pc", 32'(out_pc), 32'(exp_q[0].pc));
        chk("head.reg", 32'(out_reg), 32'(exp_q[0].rg));
        chk("head.value", 32'(out_value), 32'(exp_q[0].value));
        chk("head.addr", 32'(out_addr), 32'(exp_q[0].addr));
        chk("head.stamp", 32'(out_stamp), 32'(exp_q[0].stamp));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_pending = 1;
        end
      end else if (!out_valid) begin
        chk("idle.payload", {out_kind, out_load, out_reg, out_value}, 32'd0);
        chk("idle.addr_stamp", {out_addr, out_stamp}, 32'd0);
      end
    end
  end

  // Applies one cycle of inputs; called just after a rising edge.
  task automatic cyc(input bit rw, input bit mr, input bit mw, input bit h, input bit rdy,
                     input logic [3:0] wr, input logic [15:0] wd, input logic [15:0] ma,
                     input logic [15:0] md, input logic [15:0] p);
    reg_write = rw; mem_read = mr; mem_write = mw; hlt = h; out_ready = rdy;
    write_reg = wr; write_data = wd; mem_addr = ma; mem_data = md; pc = p;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic rnd_cyc(input int rdy_pct, input int hlt_div);
    cyc(($urandom % 3) == 0, $urandom % 2 == 1, $urandom % 2 == 1,
        (hlt_div > 0) ? (($urandom % hlt_div) == 0) : 1'b0,
        ($urandom % 100) < rdy_pct,
        4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;

    cyc(1, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0002);
    cyc(1, 1, 0, 1, 0, 4'd5, 16'hBEEF, 16'h0040, 16'h0000, 16'h0004);
    repeat (8) cyc(0, 0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'h0010);
    chk("fill.drop_count", 32'(drop_count), 32'd2);
    chk("fill.overflow", 32'(overflow), 32'd1);
    chk("fill.head_inum", 32'(out_inum), 32'd0);
    repeat (12) cyc(0, 0, 1, 0, 1, 4'd0, 16'd0, 16'h0010, 16'h00AA, 16'h0020);
    chk("stream.drop_count", 32'(drop_count), 32'd2);

    repeat (300) rnd_cyc(60, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'h0030);
    cyc(0, 0, 0, 1, 0, 4'd0, 16'd0, 16'd0, 16'd0, 16'h0032);
    chk("halt.halted", 32'(halted), 32'd1);
    repeat (5) rnd_cyc(0, 0);
    repeat (12) rnd_cyc(100, 0);
    chk("halt.drained", 32'(out_valid), 32'd0);

    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) cyc(1, 0, 0, 0, 0, 4'd7, 16'($urandom), 16'd0, 16'd0, 16'($urandom));
    #1 rst_n = 1'b0;
    model_clear();
    #1 chk("midrst.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 4'd9, 16'h5555, 16'd0, 16'd0, 16'h0100);
    chk("midrst.first_inum", 32'(out_inum), 32'd0);
    chk("midrst.first_stamp", 32'(out_stamp), 32'd0);

    repeat (400) rnd_cyc(50, 64);
    repeat (20) rnd_cyc(100, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001: Parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002: clk  input  1  rising-edge clock.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: pc  input  16  PC of the instruction retiring this cycle.
REQ-005: reg_write, mem_read, mem_write, hlt  input  1 each  retire-stage control strobes from cpu.
REQ-006: write_reg  input  4  destination register; write_data  input  16  register write value.
REQ-007: mem_addr  input  16  memory address (ALU result); mem_data  input  16  store data.
REQ-008: out_valid  output  1  head entry present; out_ready  input  1  consumer accepts head.
REQ-009: out_kind  output  2  00 NOP/branch, 01 REG, 10 STORE, 11 HALT; out_load  output  1  REG entry came from a load.
REQ-010: out_inum  output  16; out_pc  output  16; out_reg  output  4; out_value  output  16; out_addr  output  16; out_stamp  output  16.
REQ-011: halted  output  1  HALT event captured; overflow  output  1  sticky event-dropped flag; drop_count  output  8  dropped events.

Function
REQ-012: One event SHALL be classified per clock while capture is enabled; capture is enabled from the first rising edge after rst_n deasserts until a HALT is captured.
REQ-013: Classification priority SHALL be reg_write -> REG, else hlt -> HALT, else mem_write -> STORE, else NOP.
REQ-014: REG: value=write_data, reg=write_reg, load=mem_read, addr=mem_addr if mem_read else 0; STORE: addr=mem_addr, value=mem_data, reg=0; NOP/HALT: reg, value, addr = 0.
REQ-015: out_inum SHALL be a 16-bit event counter starting at 0, incremented per captured event (including dropped events), wrapping 0xFFFF -> 0x0000.
REQ-016: FIFO SHALL be first-word-fall-through; out_* SHALL show the head entry combinationally from storage while out_valid=1, and out_kind/out_load/payload SHALL read 0 while out_valid=0.
REQ-017: A pop SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-018: A push SHALL succeed when count<DEPTH, or when count==DEPTH and a pop occurs the same edge.
REQ-019: A failed push SHALL set overflow=1 (sticky) and increment drop_count, saturating at 255.
REQ-020: Push into an empty FIFO SHALL make out_valid=1 the following cycle (one-cycle latency input->output).
REQ-021: Capturing a HALT SHALL set halted=1 the same edge; no further events are captured; the FIFO continues draining.
REQ-022: A HALT event SHALL always be stored: if the FIFO is full with no pop, the HALT overwrites the tail (newest) entry, and that overwritten entry counts as dropped.
REQ-023: Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an explicit occupancy count, 0..DEPTH.

Reset
REQ-024: While rst_n=0: FIFO empty, out_valid=0, inum counter=0, halted=0, overflow=0, drop_count=0, stamp counter=0, capture disabled.
REQ-025: Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); no partial pop completes.
REQ-026: Storage contents need not be reset; outputs are masked by REQ-016.

Configuration
REQ-027: Macro RETIRE_TRACE_STAMP_EN defined: a 16-bit free-running cycle counter (0 at first capture-enabled edge, wraps) is stored per entry and presented on out_stamp.
REQ-028: Macro undefined: no cycle counter or stamp storage is built; out_stamp SHALL be constant 0.

Verification
REQ-029: Release reset, hold out_ready=0, drive reg_write=1, write_reg=3, write_data=0x1234, pc=0x0002 one cycle -> next cycle out_valid=1, kind=01, inum=0, reg=3, value=0x1234, load=0.
REQ-030: reg_write=1, mem_read=1, mem_addr=0x0040, write_data=0xBEEF -> kind=01, load=1, addr=0x0040; same cycle with hlt=1 also asserted -> still REG (priority).
REQ-031: out_ready=0, DEPTH=8, 10 NOP cycles -> count=8, overflow=1, drop_count=2, head inum=0; then out_ready=1 -> entries inum 0..7 drain in order.
REQ-032: FIFO full, out_ready=1 held, mem_write=1, mem_addr=0x0010, mem_data=0x00AA -> push accepted every cycle, overflow stays 0, STORE entry seen with addr=0x0010, value=0x00AA.
REQ-033: FIFO full, out_ready=0, hlt=1 -> halted=1, tail entry becomes kind=11, drop_count increments by 1; later events ignored; after draining, out_valid=0.
REQ-034: Assert rst_n=0 between edges while FIFO holds 5 entries -> out_valid=0 immediately; after release, first event gets inum=0; with RETIRE_TRACE_STAMP_EN, stamp=0, without it, out_stamp=0 always.
